// File: rtl/pvt_mon_pkg.sv
// Shared types and constants for the PVT ring-oscillator frequency counter.
package pvt_mon_pkg;

  localparam int unsigned ARM_CYCLES = 2;
  localparam int unsigned GATE_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_DONE
  } fcnt_state_t;

endpackage

// File: rtl/pvt_freq_counter_if.sv
// Request/result handshake between a consumer (master) and pvt_freq_counter (slave).
interface pvt_freq_counter_if
  import pvt_mon_pkg::*;
#(
  parameter int unsigned GATE_W = GATE_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              ack;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (output start, gate_len, ack, input busy, done, count, overflow);
  modport slave  (input start, gate_len, ack, output busy, done, count, overflow);

endinterface

// File: rtl/pvt_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector (one-clk pulse).
module pvt_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic [2:0] fill_q;

  // fill_q marks when prev_q holds a real sample, so a high level at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[1:0], 1'b1};
      pulse_q <= sync2_q & ~prev_q & fill_q[2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pvt_freq_counter.sv
// Gated ring-oscillator edge counter: IDLE -> ARM -> GATE -> DONE.
// Define PVT_FCNT_SATURATE_EN for a saturating edge counter; default wraps.
module pvt_freq_counter
  import pvt_mon_pkg::*;
#(
  parameter int unsigned GATE_W = GATE_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               osc_in,
  pvt_freq_counter_if.slave  bus
);

  localparam logic [1:0] ARM_LAST = 2'(ARM_CYCLES - 1);

  fcnt_state_t       state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [1:0]        arm_q, arm_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic              eovf_q, eovf_d;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              pulse;
  logic              accept, gate_last;

  pvt_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_in),
    .pulse_o (pulse)
  );

  assign accept    = (state_q == ST_IDLE) && bus.start && (bus.gate_len != '0);
  assign gate_last = (gate_q == GATE_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      arm_q   <= '0;
      edge_q  <= '0;
      eovf_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      arm_q   <= arm_d;
      edge_q  <= edge_d;
      eovf_q  <= eovf_d;
      // Result takes edge_d so a pulse in the final GATE cycle is included
      if (state_q == ST_GATE && gate_last) begin
        count_q <= edge_d;
        ovf_q   <= eovf_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)            state_d = ST_ARM;
      ST_ARM:  if (arm_q == ARM_LAST) state_d = ST_GATE;
      ST_GATE: if (gate_last)         state_d = ST_DONE;
      ST_DONE: if (bus.ack)           state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gate_d = gate_q;
    arm_d  = arm_q;
    edge_d = edge_q;
    eovf_d = eovf_q;
    if (accept) begin
      gate_d = bus.gate_len;
      arm_d  = '0;
      edge_d = '0;
      eovf_d = 1'b0;
    end else if (state_q == ST_ARM) begin
      arm_d = arm_q + 2'd1;
    end else if (state_q == ST_GATE) begin
      gate_d = gate_q - GATE_W'(1);
      if (pulse) begin
`ifdef PVT_FCNT_SATURATE_EN
        if (edge_q == '1) eovf_d = 1'b1;
        else              edge_d = edge_q + CNT_W'(1);
`else
        edge_d = edge_q + CNT_W'(1);
        if (edge_q == '1) eovf_d = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    bus.busy     = (state_q == ST_ARM) || (state_q == ST_GATE);
    bus.done     = (state_q == ST_DONE);
    bus.count    = count_q;
    bus.overflow = ovf_q;
  end

endmodule

// File: doc/pvt_freq_counter.md
PVT_FREQ_COUNTER -- requirements
Module: pvt_freq_counter

Interface
REQ-001 Parameter GATE_W, default 16: width of the gate-length input, in clk cycles.
REQ-002 Parameter CNT_W, default 16: width of the edge-count result.
REQ-003 clk  input  1  single clock for all sequential logic.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 osc_in  input  1  ring-oscillator output under measurement (inverter or NAND2 ring); asynchronous to clk.
REQ-006 start  input  1  one-cycle-or-longer request to begin a measurement.
REQ-007 gate_len  input  GATE_W  gate window length in clk cycles; sampled when start is accepted.
REQ-008 ack  input  1  consumer acknowledge of a presented result.
REQ-009 busy  output  1  high in ARM and GATE states.
REQ-010 done  output  1  result valid; high only in DONE state.
REQ-011 count  output  CNT_W  rising edges of osc_in counted during the last gate window.
REQ-012 overflow  output  1  edge counter exceeded 2^CNT_W-1 during the last window.

Function
REQ-013 The FSM SHALL have states IDLE, ARM, GATE, DONE.
REQ-014 IDLE: start=1 with gate_len!=0 SHALL latch gate_len, clear the edge counter and overflow, and move to ARM next cycle.
REQ-015 IDLE: start=1 with gate_len==0 SHALL be ignored; the FSM stays in IDLE.
REQ-016 ARM SHALL last exactly 2 cycles to flush the synchronizer; edges detected in ARM are not counted.
REQ-017 GATE SHALL last exactly the latched gate_len cycles; each synchronized rising-edge pulse in a GATE cycle increments the edge counter by 1.
REQ-018 After the last GATE cycle the FSM SHALL enter DONE, load count/overflow from the edge counter, and assert done; done is first high 3+gate_len cycles after the start-accept cycle.
REQ-019 count and overflow SHALL change only on DONE entry or reset; they hold the last result through IDLE and the following ARM/GATE.
REQ-020 DONE: done SHALL stay high until ack=1 is sampled, then the FSM returns to IDLE next cycle; ack outside DONE is ignored.
REQ-021 start outside IDLE, including in the same cycle as ack in DONE, SHALL be ignored.
REQ-022 Measurable frequency is bounded at clk/2; faster osc_in undercounts, which is not flagged.
REQ-023 Counting SHALL tolerate ±1 edge from synchronizer phase at window boundaries.

Reset
REQ-024 rst_n low SHALL force IDLE immediately, from any state including mid-GATE, with busy=0, done=0, count=0, overflow=0, synchronizer flops=0, and edge counter=0.
REQ-025 A rising osc_in level present at reset release SHALL NOT generate an edge pulse.

Configuration
REQ-026 Macro PVT_FCNT_SATURATE_EN selects overflow behaviour.
REQ-027 With PVT_FCNT_SATURATE_EN defined, the edge counter SHALL saturate at 2^CNT_W-1 and overflow is set when an increment is requested at the maximum.
REQ-028 Without the macro, the edge counter SHALL wrap modulo 2^CNT_W and overflow is set on the wrap; overflow is sticky within the window in both builds.

Structure
REQ-029 Package pvt_mon_pkg SHALL hold the FSM state enum (fcnt_state_t), ARM_CYCLES=2, and default GATE_W/CNT_W constants.
REQ-030 Sub-module pvt_sync_edge SHALL implement the 2-flop synchronizer plus a registered rising-edge detector producing a one-clk pulse.
REQ-031 The top level SHALL instantiate pvt_sync_edge once and contain the FSM, gate down-counter and edge counter.

Verification
REQ-032 osc_in=clk/4 (toggles every 2 clk), gate_len=100, start pulse -> done at cycle 103 after accept; count in 24..26; overflow=0.
REQ-033 osc_in held 0, gate_len=50 -> count=0, overflow=0; done held high for 20 cycles until ack, then IDLE.
REQ-034 CNT_W=4, osc_in=clk/4, gate_len=100 -> with PVT_FCNT_SATURATE_EN count=15, overflow=1; without the macro, count=(edges mod 16), overflow=1.
REQ-035 start with gate_len=0 -> busy stays 0, done never asserts; start held high during GATE and DONE -> no restart, single result.
REQ-036 rst_n pulsed low mid-GATE -> busy, done, count and overflow are 0 in the same cycle; a new start after release yields a full-length window.
